// File: rtl/sw_debounce_if.sv
// Switch conditioning bus: raw switch levels in, debounced levels and edge pulses out.
// The master side drives raw switches; the slave side is the debouncer.
interface sw_debounce_if #(
  parameter int WIDTH = 18
);
  logic [WIDTH-1:0] i_sw;
  logic [WIDTH-1:0] o_sw_db;
  logic [WIDTH-1:0] o_sw_rise;
  logic [WIDTH-1:0] o_sw_fall;
  logic             o_changed;

  modport master (
    output i_sw,
    input  o_sw_db,
    input  o_sw_rise,
    input  o_sw_fall,
    input  o_changed
  );

  modport slave (
    input  i_sw,
    output o_sw_db,
    output o_sw_rise,
    output o_sw_fall,
    output o_changed
  );
endinterface

// File: rtl/sw_debounce.sv
// Per-bit synchronizer plus consecutive-cycle debounce counter for the slide switches.
// Produces a stable level vector and single-cycle rise/fall pulses, all registered.
module sw_debounce #(
  parameter int WIDTH           = 18,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input logic          i_clk,
  input logic          i_rst,
  sw_debounce_if.slave sw_bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_r [SYNC_STAGES];
  logic [WIDTH-1:0] sync_last_s;
  logic [CW-1:0]    cnt_r      [WIDTH];
  logic [CW-1:0]    cnt_next_s [WIDTH];
  logic [WIDTH-1:0] db_r, rise_r, fall_r;
  logic [WIDTH-1:0] db_next_s, rise_next_s, fall_next_s;
  logic             changed_r, changed_next_s;

  assign sync_last_s = sync_r[SYNC_STAGES-1];

  // Synchronizer shift chain, no logic between stages
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_r[k] <= {WIDTH{1'b0}};
      end
    end else begin
      sync_r[0] <= sw_bus.i_sw;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_r[k] <= sync_r[k-1];
      end
    end
  end

  // Debounce decision: count consecutive deviations, accept at terminal count
  always_comb begin
    db_next_s   = db_r;
    rise_next_s = {WIDTH{1'b0}};
    fall_next_s = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next_s[i] = cnt_r[i];
      if (sync_last_s[i] == db_r[i]) begin
        cnt_next_s[i] = CNT_ZERO;
      end else if (cnt_r[i] == CNT_LAST) begin
        db_next_s[i]   = sync_last_s[i];
        cnt_next_s[i]  = CNT_ZERO;
        rise_next_s[i] = sync_last_s[i];
        fall_next_s[i] = ~sync_last_s[i];
      end else begin
        cnt_next_s[i] = cnt_r[i] + CNT_ONE;
      end
    end
    changed_next_s = |(rise_next_s | fall_next_s);
  end

  // Counter and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
      db_r      <= {WIDTH{1'b0}};
      rise_r    <= {WIDTH{1'b0}};
      fall_r    <= {WIDTH{1'b0}};
      changed_r <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_r[i] <= cnt_next_s[i];
      end
      db_r      <= db_next_s;
      rise_r    <= rise_next_s;
      fall_r    <= fall_next_s;
      changed_r <= changed_next_s;
    end
  end

  assign sw_bus.o_sw_db   = db_r;
  assign sw_bus.o_sw_rise = rise_r;
  assign sw_bus.o_sw_fall = fall_r;
  assign sw_bus.o_changed = changed_r;

endmodule
